ifu_fetch: RTL
==============

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC SHALL default to 32'h8000_0000 and set the PC value loaded on reset.
REQ-002 Parameter ISA_WIDTH SHALL default to `ISA_WIDTH` (32) and set the PC and address width.
REQ-003 Clock is clk and reset is rst; the block SHALL use one clock, with rst synchronous and active-high.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_in  in  ISA_WIDTH  next PC from execute
- pc_w_en  in  1  next-PC write strobe from execute
- pc_out  out  ISA_WIDTH  current architectural PC
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ISA_WIDTH  fetch address
- imem_rsp_valid  in  1  memory response valid
- imem_rsp_ready  out  1  block accepts response
- imem_rsp_data  in  32  fetched instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  buffered instruction
- misalign  out  1  sticky misaligned-PC flag (present only when IFU_MISALIGN_CHECK_EN is defined)

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, EXEC and HALT (HALT only with the macro defined).
REQ-006 IDLE SHALL go to REQ on the next cycle unconditionally.
REQ-007 In REQ: imem_req_valid=1 and imem_req_addr=pc_out; on imem_req_ready=1, go to WAIT next cycle.
REQ-008 In WAIT: imem_rsp_ready=1; on imem_rsp_valid=1, capture imem_rsp_data into the inst register and go to HOLD.
REQ-009 In HOLD: inst_valid=1 and inst stays stable; on inst_ready=1, go to EXEC.
REQ-010 In EXEC: on pc_w_en=1, load pc_in into the PC and go to REQ; otherwise stay in EXEC.
REQ-011 pc_w_en SHALL be ignored in every state except EXEC.
REQ-012 imem_rsp_ready SHALL be 0 outside WAIT, so responses arriving there stall rather than being dropped.
REQ-013 imem_req_valid SHALL stay high and imem_req_addr stable until accepted.
REQ-014 Best-case latency, with ready/valid high on first opportunity: REQ to inst_valid=1 in 2 cycles; pc_w_en in EXEC to the next REQ in 1 cycle.
REQ-015 pc_out SHALL change only in EXEC on pc_w_en, or on reset.
REQ-016 PC arithmetic is not performed here; pc_in SHALL be written verbatim except as in REQ-021.
REQ-017 PC wrap-around from 32'hFFFF_FFFC SHALL be the execute unit's concern; any 32-bit pc_in SHALL be accepted.

Reset
REQ-018 With rst=1 at a clk edge, the next state SHALL be: state=IDLE, pc_out=RESET_PC, inst=0, inst_valid=0, imem_req_valid=0, imem_rsp_ready=0, misalign=0.
REQ-019 rst mid-transaction (REQ, WAIT or HOLD) SHALL abandon the transaction with nothing delivered; the memory SHALL share the same rst.
REQ-020 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-021 With macro IFU_MISALIGN_CHECK_EN defined, pc_w_en=1 in EXEC with pc_in[1:0]!=0 SHALL leave the PC unchanged, set misalign=1, and enter HALT.
- HALT persists until rst.
- HALT issues no requests.
REQ-022 Without IFU_MISALIGN_CHECK_EN, the misalign port and HALT state SHALL not exist, and pc_in SHALL load unconditionally.

Verification
REQ-023 Release rst with ready/valid tied high -> imem_req_addr=32'h8000_0000 in the REQ cycle; inst_valid=1 two cycles later with inst equal to the memory word.
REQ-024 Hold imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 and addr stays stable; WAIT is entered 1 cycle after ready rises.
REQ-025 Hold inst_ready=0 for 5 cycles in HOLD -> inst_valid=1 and inst stable throughout; pc_w_en pulses during HOLD leave pc_out unchanged.
REQ-026 In EXEC, pc_in=32'h8000_0010 with pc_w_en=1 -> pc_out=32'h8000_0010 next cycle and imem_req_addr=32'h8000_0010.
REQ-027 Assert rst during WAIT with imem_rsp_valid=1 -> no capture, inst_valid=0, and fetch restarts at RESET_PC.
REQ-028 With the macro defined, pc_in=32'h8000_0006 with pc_w_en=1 in EXEC -> misalign=1, pc_out unchanged, and no further imem_req_valid until rst.

Source files
------------

// File: rtl/ifu_fetch.sv
`default_nettype none

//============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch unit. Holds the architectural PC, issues
//               one instruction-memory request per fetch over a ready/valid
//               request channel, captures the response word and presents it
//               to decode. It waits in EXEC until execute supplies the next
//               PC, then fetches again.
//
// Ports       : clk            - clock
//               rst            - synchronous active-high reset
//               pc_in          - next PC from execute
//               pc_w_en        - next-PC write strobe (honoured in EXEC only)
//               pc_out         - current architectural PC
//               imem_req_valid - fetch request valid
//               imem_req_ready - memory accepts request
//               imem_req_addr  - fetch address (always the current PC)
//               imem_rsp_valid - memory response valid
//               imem_rsp_ready - fetch unit accepts response (WAIT only)
//               imem_rsp_data  - fetched instruction word
//               inst_valid     - instruction available to decode
//               inst_ready     - decode accepts instruction
//               inst           - buffered instruction
//               misalign       - sticky misaligned-PC flag (optional)
//
// Options     : IFU_MISALIGN_CHECK_EN - when defined, a redirect to a PC
//               with pc_in[1:0] != 0 is refused, misalign is set and the
//               unit halts until reset. Without it, pc_in loads verbatim
//               and the misalign port does not exist.
//
// Revision    : 1.0 - initial release
//============================================================================

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module ifu_fetch #(
    parameter int                   ISA_WIDTH = `ISA_WIDTH,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] pc_in,
    input  logic                 pc_w_en,
    output logic [ISA_WIDTH-1:0] pc_out,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ISA_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    output logic                 imem_rsp_ready,
    input  logic [31:0]          imem_rsp_data,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                 misalign
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_EXEC = 3'd4
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        S_HALT = 3'd5
`endif
    } state_t;

    state_t                 r_state;
    logic [ISA_WIDTH-1:0]   r_pc;
    logic [31:0]            r_inst;
    logic                   r_inst_valid;
    logic                   r_req_valid;
    logic                   r_rsp_ready;
`ifdef IFU_MISALIGN_CHECK_EN
    logic                   r_misalign;
`endif

    // The handshake outputs are registered alongside the state: each one is
    // set on the transition into the state that owns it and cleared on the
    // transition out, so they always track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b0;
            r_rsp_ready  <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end

                // Request stays asserted with a stable address (the PC
                // cannot move outside EXEC) until the memory takes it.
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state      <= S_HOLD;
                        r_inst       <= imem_rsp_data;
                        r_rsp_ready  <= 1'b0;
                        r_inst_valid <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (inst_ready) begin
                        r_state      <= S_EXEC;
                        r_inst_valid <= 1'b0;
                    end
                end

                S_EXEC: begin
                    if (pc_w_en) begin
`ifdef IFU_MISALIGN_CHECK_EN
                        if (pc_in[1:0] != 2'b00) begin
                            r_state    <= S_HALT;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_pc        <= pc_in;
                            r_req_valid <= 1'b1;
                        end
`else
                        r_state     <= S_REQ;
                        r_pc        <= pc_in;
                        r_req_valid <= 1'b1;
`endif
                    end
                end

`ifdef IFU_MISALIGN_CHECK_EN
                // Terminal until reset; no requests are issued from here.
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif

                default: begin
                    r_state      <= S_IDLE;
                    r_inst_valid <= 1'b0;
                    r_req_valid  <= 1'b0;
                    r_rsp_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out         = r_pc;
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = r_req_valid;
    assign imem_rsp_ready = r_rsp_ready;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign       = r_misalign;
`endif

endmodule

`default_nettype wire
